// File: rtl/stopwatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_pkg
// Shared definitions for the stopwatch control unit:
//   - state_t      : FSM state encodings (STOP / RUN / CLEAR, 2'b11 illegal)
//   - DB_CYCLES_DEFAULT : debounce window in clk cycles, 10 ms at the 100 MHz
//                    system clock that the clock divider also assumes.
// -----------------------------------------------------------------------------
package stopwatch_ctrl_pkg;

    // Debounce window: 10 ms at 100 MHz.
    localparam int DB_CYCLES_DEFAULT = 1_000_000;

    // FSM state encodings; 2'b11 is unused and recovers to ST_STOP.
    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

endpackage : stopwatch_ctrl_pkg

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Front end for one raw push-button: 2-flop synchroniser, debounce counter and
// registered rising-edge pulse generator.
//   clk     : system clock
//   rst     : asynchronous active-low reset (0 = reset)
//   i_btn   : raw, asynchronous, bouncing button (active-high)
//   o_pulse : 1-clk pulse, the cycle after the debounced state rises
// A change on the synchronised input is accepted only after it has differed
// from the debounced state for DB_CYCLES consecutive cycles.
// -----------------------------------------------------------------------------
module btn_debounce
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic          stable_q_r;
    logic          pulse_r;
    logic [CW-1:0] cnt_r;

    // Synchroniser, debounce counter and rising-edge pulse register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b0;
            stable_q_r <= 1'b0;
            pulse_r    <= 1'b0;
            cnt_r      <= {CW{1'b0}};
        end else begin
            sync1_r    <= i_btn;
            sync2_r    <= sync1_r;
            stable_q_r <= stable_r;
            // Only presses (0->1 of the debounced state) produce an event.
            pulse_r    <= stable_r & ~stable_q_r;
            if (sync2_r != stable_r) begin
                if (cnt_r == CNT_MAX) begin
                    stable_r <= sync2_r;
                    cnt_r    <= {CW{1'b0}};
                end else begin
                    stable_r <= stable_r;
                    cnt_r    <= cnt_r + 1'b1;
                end
            end else begin
                // Input agrees with debounced state: any glitch restarts the count.
                stable_r <= stable_r;
                cnt_r    <= {CW{1'b0}};
            end
        end
    end

    assign o_pulse = pulse_r;

endmodule : btn_debounce

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control unit for the stopwatch datapath. Debounces the run/stop, clear and
// lap buttons and turns their press events into counter controls.
//   clk          : system clock (100 MHz)
//   rst          : asynchronous active-low reset (0 = reset)
//   btn_run_stop : raw run/stop button
//   btn_clear    : raw clear button
//   btn_lap      : raw lap button
//   o_run        : level, counter advances while 1
//   o_clear      : 1-clk pulse, counter clears to 0
//   o_lap_hold   : level, display shows the frozen lap value while 1
//   o_state      : current FSM state (debug / LED)
// Event priority within one cycle: run_stop > clear > lap.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_lap_hold,
    output logic [1:0] o_state
);

    logic   run_stop_pulse_s;
    logic   clear_pulse_s;
    logic   lap_pulse_s;

    state_t state_r;
    logic   run_r;
    logic   clear_r;
    logic   lap_hold_r;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run_stop (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_run_stop),
        .o_pulse (run_stop_pulse_s)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_clear),
        .o_pulse (clear_pulse_s)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_lap),
        .o_pulse (lap_pulse_s)
    );

    // Control FSM; run/clear outputs are registered alongside the state so
    // they always equal the decode of the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_STOP;
            run_r      <= 1'b0;
            clear_r    <= 1'b0;
            lap_hold_r <= 1'b0;
        end else begin
            case (state_r)
                ST_STOP: begin
                    if (run_stop_pulse_s) begin
                        state_r    <= ST_RUN;
                        run_r      <= 1'b1;
                        clear_r    <= 1'b0;
                        lap_hold_r <= lap_hold_r;
                    end else if (clear_pulse_s) begin
                        state_r    <= ST_CLEAR;
                        run_r      <= 1'b0;
                        clear_r    <= 1'b1;
                        lap_hold_r <= lap_hold_r;
                    end else begin
                        state_r    <= ST_STOP;
                        run_r      <= 1'b0;
                        clear_r    <= 1'b0;
                        // Lap while stopped releases a frozen display.
                        lap_hold_r <= lap_pulse_s ? 1'b0 : lap_hold_r;
                    end
                end
                ST_RUN: begin
                    if (run_stop_pulse_s) begin
                        // Stopping keeps whatever the display currently shows.
                        state_r    <= ST_STOP;
                        run_r      <= 1'b0;
                        clear_r    <= 1'b0;
                        lap_hold_r <= lap_hold_r;
                    end else begin
                        // Clear is ignored while running.
                        state_r    <= ST_RUN;
                        run_r      <= 1'b1;
                        clear_r    <= 1'b0;
                        lap_hold_r <= lap_pulse_s ? ~lap_hold_r : lap_hold_r;
                    end
                end
                ST_CLEAR: begin
                    // One-cycle state; events arriving now are dropped.
                    state_r    <= ST_STOP;
                    run_r      <= 1'b0;
                    clear_r    <= 1'b0;
                    lap_hold_r <= 1'b0;
                end
                default: begin
                    // Illegal encoding 2'b11 recovers to a safe stopped state.
                    state_r    <= ST_STOP;
                    run_r      <= 1'b0;
                    clear_r    <= 1'b0;
                    lap_hold_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_run      = run_r;
    assign o_clear    = clear_r;
    assign o_lap_hold = lap_hold_r;
    assign o_state    = state_r;

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed self-checking bench for stopwatch_ctrl with DB_CYCLES = 4.
// Inputs change 1 time unit after the rising edge; outputs are read at the
// same point, i.e. well after the edge that updated them.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int DB = 4;

    logic       clk;
    logic       rst;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       btn_lap;
    logic       o_run;
    logic       o_clear;
    logic       o_lap_hold;
    logic [1:0] o_state;

    int errors;
    int checks;
    int clear_cnt;
    int clear_state_cnt;

    stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
        .btn_lap      (btn_lap),
        .o_run        (o_run),
        .o_clear      (o_clear),
        .o_lap_hold   (o_lap_hold),
        .o_state      (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count clear-pulse cycles and CLEAR-state cycles, sampled mid-period.
    initial begin
        clear_cnt       = 0;
        clear_state_cnt = 0;
        forever begin
            @(negedge clk);
            if (o_clear === 1'b1)
                clear_cnt = clear_cnt + 1;
            if (o_state === 2'b10)
                clear_state_cnt = clear_state_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // which: 0 = run_stop, 1 = clear, 2 = lap
    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_run_stop = v;
            1:       btn_clear    = v;
            default: btn_lap      = v;
        endcase
    endtask

    // Clean press: hold long enough for one pulse, release, let release settle.
    task automatic press(input int which);
        set_btn(which, 1'b1);
        cyc(10);
        set_btn(which, 1'b0);
        cyc(10);
    endtask

    int n;
    int c0;
    int s0;

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        btn_run_stop = 1'b1;
        btn_clear    = 1'b1;
        btn_lap      = 1'b1;

        // ---- reset with all buttons held high ----
        cyc(3);
        check_eq("rst_run",   {7'd0, o_run},      8'd0);
        check_eq("rst_clear", {7'd0, o_clear},    8'd0);
        check_eq("rst_lap",   {7'd0, o_lap_hold}, 8'd0);
        check_eq("rst_state", {6'd0, o_state},    8'd0);
        c0  = clear_cnt;
        rst = 1'b1;
        cyc(12);
        // All three pulse together; run_stop wins, the others are dropped.
        check_eq("post_rst_state", {6'd0, o_state}, 8'd1);
        check_eq("post_rst_run",   {7'd0, o_run},   8'd1);
        check_eq("post_rst_lap",   {7'd0, o_lap_hold}, 8'd0);
        check_eq("post_rst_noclr", 8'(clear_cnt - c0), 8'd0);
        btn_run_stop = 1'b0;
        btn_clear    = 1'b0;
        btn_lap      = 1'b0;
        cyc(12);
        check_eq("held_one_pulse", {6'd0, o_state}, 8'd1);

        // ---- start/stop with latency measurement ----
        press(0);
        check_eq("stop_state", {6'd0, o_state}, 8'd0);
        btn_run_stop = 1'b1;
        n = 0;
        while (o_run !== 1'b1 && n < 30) begin
            cyc(1);
            n = n + 1;
        end
        check_eq("start_latency_ok", {7'd0, (n >= 7 && n <= 9)}, 8'd1);
        cyc(20 - n);
        btn_run_stop = 1'b0;
        cyc(10);
        check_eq("run_stays", {7'd0, o_run}, 8'd1);
        press(0);
        check_eq("stop2_run",   {7'd0, o_run},   8'd0);
        check_eq("stop2_state", {6'd0, o_state}, 8'd0);

        // ---- bounce rejection on clear, in STOP ----
        c0 = clear_cnt;
        s0 = clear_state_cnt;
        for (int i = 0; i < 4; i++) begin
            btn_clear = (i % 2 == 0) ? 1'b1 : 1'b0;
            cyc(2);
        end
        check_eq("bounce_no_clear", 8'(clear_cnt - c0), 8'd0);
        btn_clear = 1'b1;
        cyc(12);
        btn_clear = 1'b0;
        cyc(10);
        check_eq("clear_one_pulse", 8'(clear_cnt - c0), 8'd1);
        check_eq("clear_state_one", 8'(clear_state_cnt - s0), 8'd1);
        check_eq("clear_back_stop", {6'd0, o_state}, 8'd0);

        // ---- clear ignored while running ----
        press(0);
        c0 = clear_cnt;
        press(1);
        check_eq("run_clr_ignored", 8'(clear_cnt - c0), 8'd0);
        check_eq("run_clr_run",     {7'd0, o_run}, 8'd1);

        // ---- lap behaviour ----
        press(2);
        check_eq("lap_on",  {7'd0, o_lap_hold}, 8'd1);
        press(2);
        check_eq("lap_off", {7'd0, o_lap_hold}, 8'd0);
        press(2);
        press(0);
        check_eq("lap_kept_on_stop", {7'd0, o_lap_hold}, 8'd1);
        check_eq("lap_stop_state",   {6'd0, o_state},    8'd0);
        press(2);
        check_eq("lap_in_stop_off", {7'd0, o_lap_hold}, 8'd0);
        check_eq("lap_in_stop_st",  {6'd0, o_state},    8'd0);
        press(0);
        press(2);
        press(0);
        check_eq("lap_on_again", {7'd0, o_lap_hold}, 8'd1);
        press(1);
        check_eq("lap_cleared",     {7'd0, o_lap_hold}, 8'd0);
        check_eq("lap_clear_state", {6'd0, o_state},    8'd0);

        // ---- simultaneous run_stop and clear in STOP ----
        c0 = clear_cnt;
        btn_run_stop = 1'b1;
        btn_clear    = 1'b1;
        cyc(10);
        btn_run_stop = 1'b0;
        btn_clear    = 1'b0;
        cyc(10);
        check_eq("simul_state",   {6'd0, o_state}, 8'd1);
        check_eq("simul_noclear", 8'(clear_cnt - c0), 8'd0);

        // ---- reset mid-debounce discards the press ----
        press(2);
        check_eq("pre_rst_lap", {7'd0, o_lap_hold}, 8'd1);
        btn_run_stop = 1'b1;
        cyc(4);
        rst = 1'b0;
        #2;
        check_eq("mid_rst_run",   {7'd0, o_run},      8'd0);
        check_eq("mid_rst_lap",   {7'd0, o_lap_hold}, 8'd0);
        check_eq("mid_rst_state", {6'd0, o_state},    8'd0);
        cyc(2);
        btn_run_stop = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(15);
        check_eq("after_rst_state", {6'd0, o_state}, 8'd0);
        check_eq("after_rst_run",   {7'd0, o_run},   8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_stopwatch_ctrl
